// File: rtl/gbdt_pkg.sv
// Shared types and node-word layout for the GBDT tree walker.
package gbdt_pkg;

  localparam int unsigned DEF_NODE_AW   = 12;
  localparam int unsigned DEF_MAX_DEPTH = 6;

  localparam int unsigned NODE_W   = 32;
  localparam int unsigned VAL_W    = 16;
  localparam int unsigned FEAT_W   = 8;
  localparam int unsigned NUM_W    = 8;

  localparam int unsigned VAL_MSB  = 31;
  localparam int unsigned VAL_LSB  = 16;
  localparam int unsigned FEAT_MSB = 15;
  localparam int unsigned FEAT_LSB = 8;
  localparam int unsigned LEAF_BIT = 0;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    NODE_REQ = 3'd1,
    NODE_RSP = 3'd2,
    FEAT_RSP = 3'd3,
    EMIT     = 3'd4
  } gbdt_state_e;

endpackage

// File: rtl/gbdt_split_cmp.sv
// Signed threshold compare and child-slot selection for one split node.
module gbdt_split_cmp
  import gbdt_pkg::*;
#(
  parameter int unsigned IDX_W = DEF_MAX_DEPTH + 1
) (
  input  logic [VAL_W-1:0] feat_val,
  input  logic [VAL_W-1:0] threshold,
  input  logic [IDX_W-1:0] node_idx,
  output logic [IDX_W-1:0] child_idx
);

  logic go_left;

  // Left child when the feature is strictly below the threshold; heap layout 2i+1 / 2i+2.
  always_comb begin
    go_left   = $signed(feat_val) < $signed(threshold);
    child_idx = IDX_W'({node_idx, 1'b0} + (go_left ? (IDX_W+1)'(1) : (IDX_W+1)'(2)));
  end

endmodule

// File: rtl/gbdt_tree_walker.sv
// Walks a forest of heap-ordered decision trees and streams one leaf per tree to an accumulator.
module gbdt_tree_walker
  import gbdt_pkg::*;
#(
  parameter int unsigned NODE_AW   = DEF_NODE_AW,
  parameter int unsigned MAX_DEPTH = DEF_MAX_DEPTH
) (
  input  logic                gbdt_clk,
  input  logic                gbdt_rst,
  input  logic                start,
  input  logic [NUM_W-1:0]    num_trees,
  output logic                node_rd_en,
  output logic [NODE_AW-1:0]  node_addr,
  input  logic [NODE_W-1:0]   node_data,
  output logic                feat_rd_en,
  output logic [FEAT_W-1:0]   feat_addr,
  input  logic [VAL_W-1:0]    feat_val,
  output logic                start_new_round,
  output logic                enable,
  output logic                is_leaf,
  output logic                finish_condition,
  output logic [VAL_W-1:0]    leaf_val,
  output logic                busy,
  output logic                err
);

  localparam int unsigned IDX_W      = MAX_DEPTH + 1;
  localparam int unsigned TREE_SLOTS = 1 << IDX_W;
  localparam int unsigned DEPTH_W    = (MAX_DEPTH > 0) ? $clog2(MAX_DEPTH + 1) : 1;
  localparam int unsigned ADDR_W     = NUM_W + IDX_W;

  gbdt_state_e          state_q, state_d;
  logic [NUM_W-1:0]     num_q;
  logic [NUM_W-1:0]     tree_idx_q;
  logic [IDX_W-1:0]     node_idx_q;
  logic [DEPTH_W-1:0]   depth_q;
  logic [VAL_W-1:0]     thr_q;
  logic [VAL_W-1:0]     leaf_val_q;
  logic                 err_q;

  logic                 node_is_leaf;
  logic                 depth_max;
  logic                 last_tree;
  logic [IDX_W-1:0]     child_idx;
  logic [ADDR_W-1:0]    addr_full;
  logic                 node_rsvd_unused;

  // Node-word decode and walk-position status shared by FSM and datapath.
  always_comb begin
    node_is_leaf     = node_data[LEAF_BIT];
    node_rsvd_unused = ^node_data[FEAT_LSB-1:LEAF_BIT+1];
    depth_max        = (depth_q == DEPTH_W'(MAX_DEPTH));
    last_tree        = (num_q == '0) || (tree_idx_q == num_q - NUM_W'(1));
    addr_full        = ADDR_W'(tree_idx_q) * ADDR_W'(TREE_SLOTS) + ADDR_W'(node_idx_q);
  end

  gbdt_split_cmp #(
    .IDX_W (IDX_W)
  ) u_split_cmp (
    .feat_val  (feat_val),
    .threshold (thr_q),
    .node_idx  (node_idx_q),
    .child_idx (child_idx)
  );

  // State register.
  always_ff @(posedge gbdt_clk) begin
    if (gbdt_rst) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next-state selection.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (start) state_d = (num_trees == '0) ? EMIT : NODE_REQ;
      NODE_REQ: state_d = NODE_RSP;
      NODE_RSP: state_d = (node_is_leaf || depth_max) ? EMIT : FEAT_RSP;
      FEAT_RSP: state_d = NODE_REQ;
      EMIT:     state_d = last_tree ? IDLE : NODE_REQ;
      default:  state_d = IDLE;
    endcase
  end

  // Per-state strobes toward node memory, feature memory and accumulator.
  always_comb begin
    start_new_round  = 1'b0;
    node_rd_en       = 1'b0;
    node_addr        = '0;
    feat_rd_en       = 1'b0;
    feat_addr        = '0;
    enable           = 1'b0;
    is_leaf          = 1'b0;
    finish_condition = 1'b0;
    case (state_q)
      IDLE:     start_new_round = start;
      NODE_REQ: begin
        node_rd_en = 1'b1;
        node_addr  = NODE_AW'(addr_full);
      end
      NODE_RSP: begin
        if (!node_is_leaf && !depth_max) begin
          feat_rd_en = 1'b1;
          feat_addr  = node_data[FEAT_MSB:FEAT_LSB];
        end
      end
      EMIT: begin
        enable           = 1'b1;
        is_leaf          = 1'b1;
        finish_condition = last_tree;
      end
      default: ;
    endcase
  end

  // Walk position, latched threshold, leaf value and sticky overflow flag.
  always_ff @(posedge gbdt_clk) begin
    if (gbdt_rst) begin
      num_q      <= '0;
      tree_idx_q <= '0;
      node_idx_q <= '0;
      depth_q    <= '0;
      thr_q      <= '0;
      leaf_val_q <= '0;
      err_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            num_q      <= num_trees;
            tree_idx_q <= '0;
            node_idx_q <= '0;
            depth_q    <= '0;
            err_q      <= 1'b0;
            if (num_trees == '0) leaf_val_q <= '0;
          end
        end
        NODE_RSP: begin
          thr_q <= node_data[VAL_MSB:VAL_LSB];
          if (node_is_leaf) begin
            leaf_val_q <= node_data[VAL_MSB:VAL_LSB];
          end else if (depth_max) begin
            err_q      <= 1'b1;
            leaf_val_q <= '0;
          end
        end
        FEAT_RSP: begin
          node_idx_q <= child_idx;
          depth_q    <= depth_q + DEPTH_W'(1);
        end
        EMIT: begin
          if (!last_tree) begin
            tree_idx_q <= tree_idx_q + NUM_W'(1);
            node_idx_q <= '0;
            depth_q    <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign leaf_val = leaf_val_q;
  assign err      = err_q;
  assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_gbdt_tree_walker.sv
// Directed self-checking bench for gbdt_tree_walker.
module tb_gbdt_tree_walker;

  logic        gbdt_clk = 1'b0;
  logic        gbdt_rst = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  num_trees = 8'd0;
  logic        node_rd_en;
  logic [11:0] node_addr;
  logic [31:0] node_data = 32'd0;
  logic        feat_rd_en;
  logic [7:0]  feat_addr;
  logic [15:0] feat_val = 16'd0;
  logic        start_new_round, enable, is_leaf, finish_condition;
  logic [15:0] leaf_val;
  logic        busy, err;

  int errors = 0;
  int checks = 0;

  logic [31:0] node_mem [0:4095];
  logic [15:0] feat_mem [0:255];

  int en_cnt  = 0;
  int fin_cnt = 0;
  int fin_at  = 0;
  int snr_cnt = 0;
  int acc     = 0;

  gbdt_tree_walker #(.NODE_AW(12), .MAX_DEPTH(6)) dut (
    .gbdt_clk         (gbdt_clk),
    .gbdt_rst         (gbdt_rst),
    .start            (start),
    .num_trees        (num_trees),
    .node_rd_en       (node_rd_en),
    .node_addr        (node_addr),
    .node_data        (node_data),
    .feat_rd_en       (feat_rd_en),
    .feat_addr        (feat_addr),
    .feat_val         (feat_val),
    .start_new_round  (start_new_round),
    .enable           (enable),
    .is_leaf          (is_leaf),
    .finish_condition (finish_condition),
    .leaf_val         (leaf_val),
    .busy             (busy),
    .err              (err)
  );

  always #5 gbdt_clk = ~gbdt_clk;

  // One-cycle read latency memories.
  always @(posedge gbdt_clk) begin
    if (node_rd_en) node_data <= node_mem[node_addr];
    if (feat_rd_en) feat_val  <= feat_mem[feat_addr];
  end

  // Accumulator model and pulse counters.
  always @(negedge gbdt_clk) begin
    if (start_new_round) begin
      snr_cnt = snr_cnt + 1;
      acc = 0;
    end
    if (enable) begin
      en_cnt = en_cnt + 1;
      acc = acc + int'($signed(leaf_val));
      if (finish_condition) begin
        fin_cnt = fin_cnt + 1;
        fin_at  = en_cnt;
      end
    end
  end

  function automatic logic [31:0] leaf_w(input logic [15:0] v);
    return {v, 8'h00, 7'h00, 1'b1};
  endfunction

  function automatic logic [31:0] inner_w(input logic [15:0] thr, input logic [7:0] f);
    return {thr, f, 8'h00};
  endfunction

  task automatic clear_mem();
    for (int i = 0; i < 4096; i++) node_mem[i] = 32'd0;
    for (int i = 0; i < 256; i++) feat_mem[i] = 16'd0;
  endtask

  task automatic tick();
    @(posedge gbdt_clk);
    #1;
  endtask

  // Pulse start for one cycle; returns start_new_round seen in that cycle; ends in cycle 1.
  task automatic do_start(input logic [7:0] n, output logic snr);
    tick();
    start = 1'b1;
    num_trees = n;
    @(negedge gbdt_clk);
    snr = start_new_round;
    tick();
    start = 1'b0;
  endtask

  // Returns the cycle index (start cycle = 0) of the next enable, or -1 on timeout.
  task automatic wait_emit(output int cyc);
    cyc = -1;
    for (int c = 1; c <= 200; c++) begin
      @(negedge gbdt_clk);
      if (enable === 1'b1) begin
        cyc = c;
        return;
      end
    end
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 500; c++) begin
      @(negedge gbdt_clk);
      if (busy === 1'b0) begin
        ok = 1'b1;
        return;
      end
    end
  endtask

  task automatic test_reset();
    gbdt_rst = 1'b1;
    repeat (2) tick();
    @(negedge gbdt_clk);
    checks++;
    if ({busy, err, enable, is_leaf, finish_condition, start_new_round, node_rd_en, feat_rd_en} !== 8'h00) begin
      errors++;
      $display("FAIL reset_ctrl: got %b expected 00000000",
               {busy, err, enable, is_leaf, finish_condition, start_new_round, node_rd_en, feat_rd_en});
    end
    checks++;
    if (leaf_val !== 16'h0000 || node_addr !== 12'h000 || feat_addr !== 8'h00) begin
      errors++;
      $display("FAIL reset_data: got leaf=%h naddr=%h faddr=%h expected 0", leaf_val, node_addr, feat_addr);
    end
    tick();
    gbdt_rst = 1'b0;
  endtask

  task automatic test_leaf_root();
    logic snr;
    clear_mem();
    node_mem[0] = leaf_w(16'h0005);
    do_start(8'd1, snr);
    checks++;
    if (snr !== 1'b1) begin errors++; $display("FAIL leaf_snr: got %b expected 1", snr); end
    @(negedge gbdt_clk);
    checks++;
    if ({node_rd_en, busy} !== 2'b11 || node_addr !== 12'h000) begin
      errors++;
      $display("FAIL leaf_node_req: got rd=%b busy=%b addr=%h expected 1 1 000", node_rd_en, busy, node_addr);
    end
    @(negedge gbdt_clk);
    checks++;
    if ({node_rd_en, feat_rd_en, enable} !== 3'b000) begin
      errors++;
      $display("FAIL leaf_node_rsp: got %b expected 000", {node_rd_en, feat_rd_en, enable});
    end
    @(negedge gbdt_clk);
    checks++;
    if ({enable, is_leaf, finish_condition} !== 3'b111 || leaf_val !== 16'h0005) begin
      errors++;
      $display("FAIL leaf_emit: got ctl=%b leaf=%h expected 111 0005", {enable, is_leaf, finish_condition}, leaf_val);
    end
    @(negedge gbdt_clk);
    checks++;
    if ({busy, enable} !== 2'b00) begin
      errors++;
      $display("FAIL leaf_idle: got busy=%b en=%b expected 0 0", busy, enable);
    end
  endtask

  task automatic test_split();
    logic [15:0] fv  [4] = '{16'hFFFD, 16'd200, 16'd100, 16'h8000};
    logic [15:0] exv [4] = '{16'd7, 16'd9, 16'd9, 16'd7};
    logic snr;
    int   c;
    clear_mem();
    node_mem[0] = inner_w(16'd100, 8'd3);
    node_mem[1] = leaf_w(16'h0007);
    node_mem[2] = leaf_w(16'h0009);
    for (int i = 0; i < 4; i++) begin
      feat_mem[3] = fv[i];
      do_start(8'd1, snr);
      wait_emit(c);
      checks++;
      if (c !== 6 || leaf_val !== exv[i] || finish_condition !== 1'b1) begin
        errors++;
        $display("FAIL split_%0d: got cyc=%0d leaf=%h fin=%b expected cyc=6 leaf=%h fin=1",
                 i, c, leaf_val, finish_condition, exv[i]);
      end
      @(negedge gbdt_clk);
    end
  endtask

  task automatic test_busy_start();
    logic snr;
    bit   ok;
    int   snr0, en0;
    feat_mem[3] = 16'hFFFD;
    snr0 = snr_cnt;
    en0  = en_cnt;
    do_start(8'd1, snr);
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_idle(ok);
    checks++;
    if (!ok || snr_cnt - snr0 !== 1 || en_cnt - en0 !== 1 || leaf_val !== 16'h0007) begin
      errors++;
      $display("FAIL busy_start: got idle=%b snr=%0d en=%0d leaf=%h expected 1 1 1 0007",
               ok, snr_cnt - snr0, en_cnt - en0, leaf_val);
    end
  endtask

  task automatic test_zero_trees();
    logic snr;
    int   c, en0;
    en0 = en_cnt;
    do_start(8'd0, snr);
    checks++;
    if (snr !== 1'b1) begin errors++; $display("FAIL zero_snr: got %b expected 1", snr); end
    wait_emit(c);
    checks++;
    if (c !== 1 || leaf_val !== 16'h0000 || finish_condition !== 1'b1) begin
      errors++;
      $display("FAIL zero_emit: got cyc=%0d leaf=%h fin=%b expected 1 0000 1", c, leaf_val, finish_condition);
    end
    repeat (3) @(negedge gbdt_clk);
    checks++;
    if (busy !== 1'b0 || en_cnt - en0 !== 1) begin
      errors++;
      $display("FAIL zero_once: got busy=%b en=%0d expected 0 1", busy, en_cnt - en0);
    end
  endtask

  task automatic test_multi_tree();
    logic snr;
    bit   ok;
    int   en0, fin0;
    clear_mem();
    node_mem[0]   = leaf_w(16'd1);
    node_mem[128] = inner_w(16'd0, 8'd5);
    node_mem[129] = leaf_w(16'd2);
    node_mem[130] = leaf_w(16'd50);
    node_mem[256] = leaf_w(16'd3);
    feat_mem[5]   = 16'hFFFF;
    en0  = en_cnt;
    fin0 = fin_cnt;
    do_start(8'd3, snr);
    wait_idle(ok);
    checks++;
    if (!ok || en_cnt - en0 !== 3 || fin_cnt - fin0 !== 1 || fin_at !== en0 + 3) begin
      errors++;
      $display("FAIL multi_pulses: got idle=%b en=%0d fin=%0d fin_at=%0d expected 1 3 1 3",
               ok, en_cnt - en0, fin_cnt - fin0, fin_at - en0);
    end
    checks++;
    if (acc !== 6) begin errors++; $display("FAIL multi_acc: got %0d expected 6", acc); end
  endtask

  task automatic test_overflow();
    logic snr;
    bit   ok;
    int   c;
    clear_mem();
    for (int i = 0; i < 128; i++) node_mem[i] = inner_w(16'd100, 8'd0);
    do_start(8'd1, snr);
    wait_emit(c);
    checks++;
    if (c !== 21 || leaf_val !== 16'h0000 || err !== 1'b1 || finish_condition !== 1'b1) begin
      errors++;
      $display("FAIL ovf_emit: got cyc=%0d leaf=%h err=%b fin=%b expected 21 0000 1 1",
               c, leaf_val, err, finish_condition);
    end
    repeat (2) @(negedge gbdt_clk);
    checks++;
    if ({busy, err} !== 2'b01) begin
      errors++;
      $display("FAIL ovf_sticky: got busy=%b err=%b expected 0 1", busy, err);
    end
    node_mem[0] = leaf_w(16'd4);
    do_start(8'd1, snr);
    @(negedge gbdt_clk);
    checks++;
    if (err !== 1'b0) begin errors++; $display("FAIL ovf_clear: got err=%b expected 0", err); end
    wait_idle(ok);
  endtask

  task automatic test_reset_mid();
    logic snr;
    int   c, en0;
    clear_mem();
    node_mem[0]   = leaf_w(16'd1);
    node_mem[128] = inner_w(16'd50, 8'd2);
    node_mem[129] = leaf_w(16'd4);
    node_mem[130] = leaf_w(16'd8);
    feat_mem[2]   = 16'd10;
    en0 = en_cnt;
    do_start(8'd2, snr);
    repeat (5) tick();
    gbdt_rst = 1'b1;
    @(negedge gbdt_clk);
    checks++;
    if ({busy, node_rd_en, feat_rd_en, enable} !== 4'b1000 || en_cnt - en0 !== 1) begin
      errors++;
      $display("FAIL rst_pre: got ctl=%b en=%0d expected 1000 1", {busy, node_rd_en, feat_rd_en, enable}, en_cnt - en0);
    end
    tick();
    gbdt_rst = 1'b0;
    @(negedge gbdt_clk);
    checks++;
    if ({busy, err, enable, is_leaf, finish_condition, start_new_round, node_rd_en, feat_rd_en} !== 8'h00
        || leaf_val !== 16'h0000) begin
      errors++;
      $display("FAIL rst_mid: got ctl=%b leaf=%h expected 00000000 0000",
               {busy, err, enable, is_leaf, finish_condition, start_new_round, node_rd_en, feat_rd_en}, leaf_val);
    end
    repeat (10) tick();
    checks++;
    if (en_cnt - en0 !== 1) begin errors++; $display("FAIL rst_no_enable: got %0d expected 1", en_cnt - en0); end
    do_start(8'd1, snr);
    wait_emit(c);
    checks++;
    if (c !== 3 || leaf_val !== 16'd1 || finish_condition !== 1'b1) begin
      errors++;
      $display("FAIL rst_restart: got cyc=%0d leaf=%h fin=%b expected 3 0001 1", c, leaf_val, finish_condition);
    end
    @(negedge gbdt_clk);
  endtask

  initial begin
    clear_mem();
    test_reset();
    test_leaf_root();
    test_split();
    test_busy_start();
    test_zero_trees();
    test_multi_tree();
    test_overflow();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
